// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and data load/store; one-cycle completion pulses per requester.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              idle
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_d;   // last grant went to data
  logic       owner_d;  // current access belongs to data
  logic       f_elig, grant_d, grant_f, last_beat;

  assign f_elig    = if_req & ~halt;
  assign last_beat = (cnt == 4'(MEM_LAT - 1));
  assign idle      = (state == IDLE);
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    case (state)
      IDLE: begin
        // on a tie the requester that did not win last time goes first
        grant_d = d_req & (~f_elig | ~last_d);
        grant_f = f_elig & ~grant_d;
        if (grant_d | grant_f) state_nxt = BUSY;
      end
      BUSY:    if (last_beat) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      last_d    <= 1'b0;
      owner_d   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: if (grant_d | grant_f) begin
          mem_en    <= 1'b1;
          mem_wr    <= grant_d & d_wr;
          mem_addr  <= grant_d ? d_addr : if_addr;
          mem_wdata <= grant_d ? d_wdata : '0;
          owner_d   <= grant_d;
          last_d    <= grant_d;
          cnt       <= '0;
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          if (last_beat) begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            if (owner_d) begin
              d_valid <= 1'b1;
              d_rdata <= mem_wr ? '0 : mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each
// access (owner, address, data, grant cycle); a negedge monitor checks the DUT.
module tb_mem_arbiter;
  localparam int AW = 16, DW = 16, L = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic halt, if_req, d_req, d_wr;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic if_valid, if_stall, d_valid, d_stall, mem_en, mem_wr, idle;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .idle(idle));

  always #5 clk = ~clk;

  typedef struct {
    bit d; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata; int g;
  } acc_t;

  acc_t q[$];
  logic [DW-1:0] ram [0:65535];   // memory macro stand-in
  logic [DW-1:0] mdl [0:65535];   // reference model's view of memory
  int cyc = 0, n_chk = 0, n_fail = 0, next_idle = 0;
  bit last_d = 1'b0, f_fly = 1'b0, d_fly = 1'b0;
  logic [DW-1:0] exp_if_rd = '0, exp_d_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem_en ? ram[mem_addr] : '0;
  always @(posedge clk) if (mem_en && mem_wr) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Access-level model: at most one access every L+2 cycles, latched at grant.
  task automatic model();
    bit fe, pd;
    acc_t a;
    if (rst || cyc < next_idle) return;
    fe = if_req && !halt;
    if (!fe && !d_req) return;
    pd = d_req && (!fe || !last_d);
    a.d = pd; a.g = cyc; a.wr = pd && d_wr;
    a.addr = pd ? d_addr : if_addr;
    a.wdata = d_wdata;
    if (a.wr) begin mdl[a.addr] = a.wdata; a.rdata = '0; end
    else a.rdata = mdl[a.addr];
    last_d = pd;
    if (pd) d_fly = 1'b1; else f_fly = 1'b1;
    q.push_back(a);
    next_idle = cyc + L + 2;
  endtask

  // mode 0: directed (drop on completion), 1: re-raise both at once, 2: random traffic
  task automatic cycle_step(input int mode);
    @(posedge clk); #1;
    if (if_valid) begin
      f_fly = 1'b0; if_req = 1'b0;
      if (mode == 1) begin if_req = 1'b1; if_addr = 16'($urandom_range(0, 31)); end
    end
    if (d_valid) begin
      d_fly = 1'b0; d_req = 1'b0;
      if (mode == 1) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom_range(0, 31)); end
    end
    if (mode == 2) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 31));
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 31)); d_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 9) == 0) halt = !halt;
    end
    // inputs wander once granted; only the latched copy may reach memory
    if (d_fly) begin d_addr = 16'hFFFF; d_wdata = ~d_wdata; d_wr = !d_wr; end
    if (f_fly) if_addr = 16'($urandom);
    model();
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || if_req || d_req) && n < 100) begin cycle_step(0); n++; end
    chk("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  always @(negedge clk) begin : mon
    bit en, v, busy;
    acc_t a;
    if (rst !== 1'b0) disable mon;
    en = 1'b0; v = 1'b0; busy = 1'b0;
    if (q.size() > 0) begin
      a = q[0];
      busy = cyc > a.g;
      en = busy && cyc <= a.g + L;
      v = cyc == a.g + L + 1;
    end
    chk("mem_en", 32'(mem_en), 32'(en));
    chk("idle", 32'(idle), 32'(!busy));
    if (en) begin
      chk("mem_addr", 32'(mem_addr), 32'(a.addr));
      chk("mem_wr", 32'(mem_wr), 32'(a.wr));
      if (a.wr) chk("mem_wdata", 32'(mem_wdata), 32'(a.wdata));
    end else chk("mem_wr_off", 32'(mem_wr), 32'd0);
    chk("if_valid", 32'(if_valid), 32'(v && !a.d));
    chk("d_valid", 32'(d_valid), 32'(v && a.d));
    chk("if_stall", 32'(if_stall), 32'(if_req && !(v && !a.d)));
    chk("d_stall", 32'(d_stall), 32'(d_req && !(v && a.d)));
    if (v) begin
      if (a.d) exp_d_rd = a.rdata; else exp_if_rd = a.rdata;
      void'(q.pop_front());
    end
    chk("if_rdata", 32'(if_rdata), 32'(exp_if_rd));
    chk("d_rdata", 32'(d_rdata), 32'(exp_d_rd));
  end

  initial begin
    int n;
    halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i * 40503) ^ 16'h5A5A;
      mdl[i] = ram[i];
    end
    ram[16'h0010] = 16'hA123; mdl[16'h0010] = 16'hA123;
    ram[16'h0200] = 16'h0C0D; mdl[16'h0200] = 16'h0C0D;

    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_valids", 32'({if_valid, d_valid}), 32'd0);
    chk("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    next_idle = cyc;

    // single fetch from 0x0010
    if_req = 1'b1; if_addr = 16'h0010;
    model();
    drain();

    // simultaneous fetch + load: data first, then fetch
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    model();
    drain();

    // both held continuously: grants alternate
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0008;
    model();
    repeat (4 * (L + 2) + 1) cycle_step(1);
    drain();

    // store then load back from 0x0300
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
    model();
    drain();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
    model();
    drain();

    // halt blocks fetch grants but not data
    halt = 1'b1;
    if_req = 1'b1; if_addr = 16'h0005;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0007;
    model();
    repeat (20) cycle_step(0);
    halt = 1'b0;
    model();
    drain();

    // random traffic
    repeat (1500) cycle_step(2);
    halt = 1'b0;
    drain();

    // reset in the third BUSY cycle of a fetch
    if_req = 1'b1; if_addr = 16'h0010;
    model();
    n = 0;
    while (!(q.size() > 0 && cyc == q[0].g + 3) && n < 50) begin cycle_step(0); n++; end
    chk("rst_wait", 32'(n < 50), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_mem_regs", 32'({mem_wr, mem_addr}), 32'd0);
    chk("midrst_wdata", 32'(mem_wdata), 32'd0);
    chk("midrst_valids", 32'({if_valid, d_valid}), 32'd0);
    chk("midrst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    q.delete();
    last_d = 1'b0; f_fly = 1'b0; d_fly = 1'b0;
    exp_if_rd = '0; exp_d_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    next_idle = cyc;
    model();
    drain();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
